// File: rtl/reg_pkg.sv
// Shared register-file types: physical index, write/NZCV port structs, wakeup entry.
package reg_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PW            = $clog2(NUM_PHYS_REGS);
  localparam int NZCV_WIDTH    = 4;

  typedef logic [PW-1:0] PhysIdx;

  typedef struct packed {
    logic                 en;
    PhysIdx               index_in;
    logic [WORD_SIZE-1:0] data_in;
  } RegFileWritePort;

  typedef struct packed {
    logic                  valid;
    PhysIdx                index_in;
    logic [NZCV_WIDTH-1:0] nzcv;
  } NZCVWritePort;

  typedef struct packed {
    logic   valid;
    PhysIdx index;
  } WakeupPort;

endpackage

// File: rtl/prf_scoreboard.sv
// Ready-bit scoreboard: writes set, rename allocs clear (clear beats set),
// phys reg 0 pinned ready when the zero register is enabled.
module prf_scoreboard
  import reg_pkg::*;
#(
  parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS   = 32,
  parameter int NUM_ALLOC_PORTS = 2,
  parameter int PW              = $clog2(NUM_PHYS_REGS),
  parameter int ZERO_REG_EN     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ALLOC_PORTS-1:0]          alloc_en,
  input  logic [NUM_ALLOC_PORTS-1:0][PW-1:0]  alloc_index,
  input  logic [NUM_PHYS_REGS-1:0]            set_mask,
  output logic [NUM_PHYS_REGS-1:0]            scoreboard
);

  logic [NUM_PHYS_REGS-1:0] clr_mask;
  logic [NUM_PHYS_REGS-1:0] sb_next;
  logic [NUM_PHYS_REGS-1:0] reset_pattern;

  // Architectural registers are mapped and ready out of reset.
  for (genvar g = 0; g < NUM_PHYS_REGS; g++) begin : g_rst
    assign reset_pattern[g] = (g < NUM_ARCH_REGS) || ((ZERO_REG_EN != 0) && (g == 0));
  end

  // Decode rename allocations into a clear mask.
  always_comb begin
    clr_mask = '0;
    for (int a = 0; a < NUM_ALLOC_PORTS; a++)
      if (alloc_en[a]) clr_mask[alloc_index[a]] = 1'b1;
  end

  // Alloc wins over a same-cycle write; zero register stays ready.
  always_comb begin
    sb_next = (scoreboard | set_mask) & ~clr_mask;
    if (ZERO_REG_EN != 0) sb_next[0] = 1'b1;
  end

  // Scoreboard state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) scoreboard <= reset_pattern;
    else      scoreboard <= sb_next;
  end

endmodule

// File: rtl/prf_bypass_regfile.sv
// Physical register file with same-cycle write bypass, registered wakeup
// broadcast, hardwired zero register and write conflict/overcommit flags.
// The NZCV write is treated as write slot NUM_WRITE_PORTS (lowest priority).
module prf_bypass_regfile
  import reg_pkg::*;
#(
  parameter int WORD_SIZE       = reg_pkg::WORD_SIZE,
  parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS   = 32,
  parameter int NUM_READ_PORTS  = 4,
  parameter int NUM_WRITE_PORTS = 8,
  parameter int NUM_ALLOC_PORTS = 2,
  parameter int MAX_WRITES      = 2,
  parameter int ZERO_REG_EN     = 1,
  localparam int PW             = $clog2(NUM_PHYS_REGS)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_READ_PORTS-1:0]                     read_en,
  input  logic [NUM_READ_PORTS-1:0][PW-1:0]             read_index,
  output logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0]      read_data,
  output logic [NUM_READ_PORTS-1:0]                     read_ready,
  input  logic [NUM_ALLOC_PORTS-1:0]                    alloc_en,
  input  logic [NUM_ALLOC_PORTS-1:0][PW-1:0]            alloc_index,
  input  RegFileWritePort [NUM_WRITE_PORTS-1:0]         write_ports,
  input  NZCVWritePort                                  nzcv_write_port,
  output logic [NUM_PHYS_REGS-1:0]                      scoreboard,
  output logic [NUM_WRITE_PORTS:0]                      wakeup_valid,
  output logic [NUM_WRITE_PORTS:0][PW-1:0]              wakeup_index,
  output logic                                          conflict_err,
  output logic                                          overcommit_err
);

  localparam int NWT = NUM_WRITE_PORTS + 1;

  logic [NUM_PHYS_REGS-1:0][WORD_SIZE-1:0] regs;
  logic [NWT-1:0]                          w_en;
  logic [NWT-1:0]                          w_eff;
  logic [NWT-1:0][PW-1:0]                  w_idx;
  logic [NWT-1:0][WORD_SIZE-1:0]           w_data;
  logic [NUM_PHYS_REGS-1:0]                set_mask;
  logic [NUM_READ_PORTS-1:0]               rd_hit;
  logic                                    dup_hit;
  int                                      wr_cnt;
  WakeupPort [NWT-1:0]                     wk_q;

  // Flatten GPR ports and NZCV into one write-slot view; writes to the
  // zero register are enabled (they count toward overcommit) but not effective.
  always_comb begin
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      w_en[i]   = write_ports[i].en;
      w_idx[i]  = write_ports[i].index_in;
      w_data[i] = write_ports[i].data_in;
    end
    w_en[NWT-1]   = nzcv_write_port.valid;
    w_idx[NWT-1]  = nzcv_write_port.index_in;
    w_data[NWT-1] = {{(WORD_SIZE-NZCV_WIDTH){1'b0}}, nzcv_write_port.nzcv};
    for (int i = 0; i < NWT; i++)
      w_eff[i] = w_en[i] && !((ZERO_REG_EN != 0) && (w_idx[i] == '0));
  end

  // Scoreboard set mask from effective writes.
  always_comb begin
    set_mask = '0;
    for (int i = 0; i < NWT; i++)
      if (w_eff[i]) set_mask[w_idx[i]] = 1'b1;
  end

  prf_scoreboard #(
    .NUM_PHYS_REGS   (NUM_PHYS_REGS),
    .NUM_ARCH_REGS   (NUM_ARCH_REGS),
    .NUM_ALLOC_PORTS (NUM_ALLOC_PORTS),
    .PW              (PW),
    .ZERO_REG_EN     (ZERO_REG_EN)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_index (alloc_index),
    .set_mask    (set_mask),
    .scoreboard  (scoreboard)
  );

  // Data array; walk slots high to low so the lowest-numbered writer lands last.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      for (int i = NWT - 1; i >= 0; i--)
        if (w_eff[i]) regs[w_idx[i]] <= w_data[i];
    end
  end

  // Read with bypass: lowest matching write slot wins, else array + scoreboard.
  always_comb begin
    read_data  = '0;
    read_ready = '0;
    rd_hit     = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (read_en[p]) begin
        for (int i = NWT - 1; i >= 0; i--) begin
          if (w_eff[i] && (w_idx[i] == read_index[p])) begin
            rd_hit[p]    = 1'b1;
            read_data[p] = w_data[i];
          end
        end
        if (rd_hit[p]) begin
          read_ready[p] = 1'b1;
        end else if ((ZERO_REG_EN != 0) && (read_index[p] == '0)) begin
          read_data[p]  = '0;
          read_ready[p] = 1'b1;
        end else begin
          read_data[p]  = regs[read_index[p]];
          read_ready[p] = scoreboard[read_index[p]];
        end
      end
    end
  end

  // Error detection: duplicate effective targets and enabled-write popcount.
  always_comb begin
    dup_hit = 1'b0;
    wr_cnt  = 0;
    for (int i = 0; i < NWT; i++) begin
      if (w_en[i]) wr_cnt = wr_cnt + 1;
      for (int j = i + 1; j < NWT; j++)
        if (w_eff[i] && w_eff[j] && (w_idx[i] == w_idx[j])) dup_hit = 1'b1;
    end
  end

  // One-cycle wakeup strobes and error flags, registered from this cycle's writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wk_q           <= '0;
      conflict_err   <= 1'b0;
      overcommit_err <= 1'b0;
    end else begin
      for (int i = 0; i < NWT; i++) begin
        wk_q[i].valid <= w_eff[i];
        wk_q[i].index <= w_eff[i] ? w_idx[i] : '0;
      end
      conflict_err   <= dup_hit;
      overcommit_err <= (wr_cnt > MAX_WRITES);
    end
  end

  for (genvar g = 0; g < NWT; g++) begin : g_wk
    assign wakeup_valid[g] = wk_q[g].valid;
    assign wakeup_index[g] = wk_q[g].index;
  end

endmodule

// File: tb/tb_prf_bypass_regfile.sv
// Scenario bench for prf_bypass_regfile: expectations are queued when stimulus
// is driven and popped when the corresponding output is sampled.
module tb_prf_bypass_regfile;
  import reg_pkg::*;

  localparam int NR = 4;
  localparam int NW = 8;
  localparam int NA = 2;
  localparam int NP = 64;
  localparam int P  = 6;

  logic                       clk;
  logic                       rst;
  logic [NR-1:0]              read_en;
  logic [NR-1:0][P-1:0]       read_index;
  logic [NR-1:0][31:0]        read_data;
  logic [NR-1:0]              read_ready;
  logic [NA-1:0]              alloc_en;
  logic [NA-1:0][P-1:0]       alloc_index;
  RegFileWritePort [NW-1:0]   write_ports;
  NZCVWritePort               nzcv_write_port;
  logic [NP-1:0]              scoreboard;
  logic [NW:0]                wakeup_valid;
  logic [NW:0][P-1:0]         wakeup_index;
  logic                       conflict_err;
  logic                       overcommit_err;

  logic [127:0] exp_q[$];
  logic [127:0] exp;
  int n_cmp;
  int n_bad;

  prf_bypass_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .read_en         (read_en),
    .read_index      (read_index),
    .read_data       (read_data),
    .read_ready      (read_ready),
    .alloc_en        (alloc_en),
    .alloc_index     (alloc_index),
    .write_ports     (write_ports),
    .nzcv_write_port (nzcv_write_port),
    .scoreboard      (scoreboard),
    .wakeup_valid    (wakeup_valid),
    .wakeup_index    (wakeup_index),
    .conflict_err    (conflict_err),
    .overcommit_err  (overcommit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    read_en         = '0;
    read_index      = '0;
    alloc_en        = '0;
    alloc_index     = '0;
    write_ports     = '0;
    nzcv_write_port = '0;
  endtask

  task automatic wr(input int port, input int idx, input logic [31:0] data);
    write_ports[port].en       = 1'b1;
    write_ports[port].index_in = P'(idx);
    write_ports[port].data_in  = data;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    read_en = '1;
    read_index[0] = 6'd31; read_index[1] = 6'd0; read_index[2] = 6'd40; read_index[3] = 6'd5;
    exp_q.push_back(128'h0000_0000_FFFF_FFFF);
    exp_q.push_back(128'd0);
    exp_q.push_back(128'd0);
    exp_q.push_back(128'b1011);
    exp_q.push_back(128'd0);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(scoreboard) !== exp) begin n_bad++; $display("FAIL reset_scoreboard: got %h want %h", scoreboard, exp[63:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(wakeup_valid) !== exp) begin n_bad++; $display("FAIL reset_wakeup: got %b want %b", wakeup_valid, exp[8:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'({conflict_err, overcommit_err}) !== exp) begin n_bad++; $display("FAIL reset_errs: got %b%b want 00", conflict_err, overcommit_err); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(read_ready) !== exp) begin n_bad++; $display("FAIL reset_ready: got %b want %b", read_ready, exp[3:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(read_data) !== exp) begin n_bad++; $display("FAIL reset_data: got %h want 0", read_data); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    clear_inputs();
    wr(3, 40, 32'hDEAD);
    read_en[0] = 1'b1; read_index[0] = 6'd40;
    exp_q.push_back(128'h1_0000_DEAD);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if ({read_ready[0], read_data[0]} !== exp[32:0]) begin n_bad++; $display("FAIL bypass_read: got %b/%h want 1/%h", read_ready[0], read_data[0], exp[31:0]); end
    exp_q.push_back(128'b000001000);
    exp_q.push_back(128'd40);
    exp_q.push_back(128'h1_0000_DEAD);
    @(posedge clk); #1;
    clear_inputs();
    read_en[0] = 1'b1; read_index[0] = 6'd40;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(wakeup_valid) !== exp) begin n_bad++; $display("FAIL bypass_wk_valid: got %b want %b", wakeup_valid, exp[8:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(wakeup_index[3]) !== exp) begin n_bad++; $display("FAIL bypass_wk_index: got %0d want %0d", wakeup_index[3], exp[5:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if ({scoreboard[40], read_data[0]} !== exp[32:0]) begin n_bad++; $display("FAIL bypass_array: got %b/%h want 1/%h", scoreboard[40], read_data[0], exp[31:0]); end
    exp_q.push_back(128'd0);
    @(posedge clk); #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(wakeup_valid) !== exp) begin n_bad++; $display("FAIL bypass_wk_oneshot: got %b want 0", wakeup_valid); end
  endtask

  task automatic test_alloc();
    @(negedge clk);
    clear_inputs();
    alloc_en[0] = 1'b1; alloc_index[0] = 6'd40;
    exp_q.push_back(128'h0_0000_DEAD);
    @(posedge clk); #1;
    clear_inputs();
    read_en[0] = 1'b1; read_index[0] = 6'd40;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if ({read_ready[0], read_data[0]} !== exp[32:0]) begin n_bad++; $display("FAIL alloc_clear: got %b/%h want 0/%h", read_ready[0], read_data[0], exp[31:0]); end
    @(negedge clk);
    clear_inputs();
    alloc_en[1] = 1'b1; alloc_index[1] = 6'd41;
    wr(0, 41, 32'h4141);
    read_en[2] = 1'b1; read_index[2] = 6'd41;
    exp_q.push_back(128'h1_0000_4141);
    exp_q.push_back(128'h0_0000_4141);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if ({read_ready[2], read_data[2]} !== exp[32:0]) begin n_bad++; $display("FAIL alloc_write_bypass: got %b/%h want 1/%h", read_ready[2], read_data[2], exp[31:0]); end
    @(posedge clk); #1;
    clear_inputs();
    read_en[2] = 1'b1; read_index[2] = 6'd41;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if ({scoreboard[41], read_data[2]} !== exp[32:0]) begin n_bad++; $display("FAIL alloc_wins: got %b/%h want 0/%h", scoreboard[41], read_data[2], exp[31:0]); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    clear_inputs();
    wr(1, 50, 32'h11);
    wr(5, 50, 32'h55);
    read_en[1] = 1'b1; read_index[1] = 6'd50;
    exp_q.push_back(128'h11);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(read_data[1]) !== exp) begin n_bad++; $display("FAIL conflict_bypass: got %h want %h", read_data[1], exp[31:0]); end
    exp_q.push_back(128'b10);
    exp_q.push_back(128'b000100010);
    exp_q.push_back(128'h11);
    @(posedge clk); #1;
    clear_inputs();
    read_en[1] = 1'b1; read_index[1] = 6'd50;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'({conflict_err, overcommit_err}) !== exp) begin n_bad++; $display("FAIL conflict_flag: got %b%b want 10", conflict_err, overcommit_err); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(wakeup_valid) !== exp) begin n_bad++; $display("FAIL conflict_wakeups: got %b want %b", wakeup_valid, exp[8:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(read_data[1]) !== exp) begin n_bad++; $display("FAIL conflict_winner: got %h want %h", read_data[1], exp[31:0]); end
    exp_q.push_back(128'd0);
    @(posedge clk); #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(conflict_err) !== exp) begin n_bad++; $display("FAIL conflict_oneshot: got %b want 0", conflict_err); end
  endtask

  task automatic test_overcommit();
    @(negedge clk);
    clear_inputs();
    wr(0, 10, 32'hA0A0);
    wr(2, 11, 32'hB1B1);
    wr(6, 12, 32'hC2C2);
    nzcv_write_port.valid = 1'b1; nzcv_write_port.index_in = 6'd13; nzcv_write_port.nzcv = 4'hF;
    exp_q.push_back(128'b01);
    exp_q.push_back({32'hF, 32'hC2C2, 32'hB1B1, 32'hA0A0});
    @(posedge clk); #1;
    clear_inputs();
    read_en = '1;
    read_index[0] = 6'd10; read_index[1] = 6'd11; read_index[2] = 6'd12; read_index[3] = 6'd13;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'({conflict_err, overcommit_err}) !== exp) begin n_bad++; $display("FAIL overcommit_flag: got %b%b want 01", conflict_err, overcommit_err); end
    exp = exp_q.pop_front(); n_cmp++;
    if (read_data !== exp) begin n_bad++; $display("FAIL overcommit_data: got %h want %h", read_data, exp); end
    exp_q.push_back(128'd0);
    @(posedge clk); #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(overcommit_err) !== exp) begin n_bad++; $display("FAIL overcommit_oneshot: got %b want 0", overcommit_err); end
  endtask

  task automatic test_nzcv();
    @(negedge clk);
    clear_inputs();
    wr(7, 20, 32'h77);
    nzcv_write_port.valid = 1'b1; nzcv_write_port.index_in = 6'd20; nzcv_write_port.nzcv = 4'h5;
    read_en[0] = 1'b1; read_index[0] = 6'd20;
    exp_q.push_back(128'h77);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(read_data[0]) !== exp) begin n_bad++; $display("FAIL nzcv_prio_bypass: got %h want %h", read_data[0], exp[31:0]); end
    exp_q.push_back(128'b110000000);
    exp_q.push_back(128'h77);
    @(posedge clk); #1;
    clear_inputs();
    read_en[0] = 1'b1; read_index[0] = 6'd20;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(wakeup_valid) !== exp) begin n_bad++; $display("FAIL nzcv_wakeup: got %b want %b", wakeup_valid, exp[8:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(read_data[0]) !== exp) begin n_bad++; $display("FAIL nzcv_prio_array: got %h want %h", read_data[0], exp[31:0]); end
    @(negedge clk);
    clear_inputs();
    nzcv_write_port.valid = 1'b1; nzcv_write_port.index_in = 6'd21; nzcv_write_port.nzcv = 4'hA;
    read_en[3] = 1'b1; read_index[3] = 6'd21;
    exp_q.push_back(128'h1_0000_000A);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if ({read_ready[3], read_data[3]} !== exp[32:0]) begin n_bad++; $display("FAIL nzcv_zext: got %b/%h want 1/%h", read_ready[3], read_data[3], exp[31:0]); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    clear_inputs();
    wr(2, 0, 32'h1234);
    alloc_en[0] = 1'b1; alloc_index[0] = 6'd0;
    read_en[1] = 1'b1; read_index[1] = 6'd0;
    exp_q.push_back(128'h1_0000_0000);
    #2;
    exp = exp_q.pop_front(); n_cmp++;
    if ({read_ready[1], read_data[1]} !== exp[32:0]) begin n_bad++; $display("FAIL zero_bypass: got %b/%h want 1/0", read_ready[1], read_data[1]); end
    exp_q.push_back(128'd0);
    exp_q.push_back(128'h3_0000_0000);
    @(posedge clk); #1;
    clear_inputs();
    read_en[1] = 1'b1; read_index[1] = 6'd0;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(wakeup_valid) !== exp) begin n_bad++; $display("FAIL zero_no_wakeup: got %b want 0", wakeup_valid); end
    exp = exp_q.pop_front(); n_cmp++;
    if ({scoreboard[0], read_ready[1], read_data[1]} !== exp[33:0]) begin n_bad++; $display("FAIL zero_state: got sb=%b rdy=%b data=%h want 1/1/0", scoreboard[0], read_ready[1], read_data[1]); end
    @(negedge clk);
    clear_inputs();
    wr(0, 0, 32'h1);
    wr(1, 0, 32'h2);
    wr(2, 30, 32'h3030);
    exp_q.push_back(128'b01);
    @(posedge clk); #1;
    clear_inputs();
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(overcommit_err) !== exp) begin n_bad++; $display("FAIL zero_overcommit: got %b want 1", overcommit_err); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear_inputs();
    wr(4, 60, 32'h99);
    @(negedge clk);
    clear_inputs();
    wr(0, 61, 32'h61);
    wr(1, 61, 32'h62);
    wr(2, 62, 32'h63);
    alloc_en[0] = 1'b1; alloc_index[0] = 6'd5;
    rst = 1'b0;
    exp_q.push_back(128'h0000_0000_FFFF_FFFF);
    exp_q.push_back(128'd0);
    exp_q.push_back(128'd0);
    @(posedge clk); #1;
    clear_inputs();
    read_en[0] = 1'b1; read_index[0] = 6'd60;
    read_en[1] = 1'b1; read_index[1] = 6'd61;
    #1;
    exp = exp_q.pop_front(); n_cmp++;
    if (128'(scoreboard) !== exp) begin n_bad++; $display("FAIL midreset_scoreboard: got %h want %h", scoreboard, exp[63:0]); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'({wakeup_valid, conflict_err, overcommit_err}) !== exp) begin n_bad++; $display("FAIL midreset_flags: got wk=%b c=%b o=%b want 0", wakeup_valid, conflict_err, overcommit_err); end
    exp = exp_q.pop_front(); n_cmp++;
    if (128'({read_data[1], read_data[0]}) !== exp) begin n_bad++; $display("FAIL midreset_data: got %h %h want 0", read_data[1], read_data[0]); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_bypass();
    test_alloc();
    test_conflict();
    test_overcommit();
    test_nzcv();
    test_zero_reg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
